// File: rtl/chord_sequencer.sv
// Chord sequencer: walks a song ROM, groups up to four note entries into a chord,
// hands each chord to the player and waits for it to finish before fetching more.
module chord_sequencer #(
    parameter int SONG_ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   play_enable,
    input  logic                   new_song,
    input  logic [1:0]             song,
    input  logic                   done_with_note,
    output logic [SONG_ADDR_W+1:0] rom_addr,
    input  logic [15:0]            rom_data,
    output logic [5:0]             note1,
    output logic [5:0]             note2,
    output logic [5:0]             note3,
    output logic [5:0]             note4,
    output logic [2:0]             metadata1,
    output logic [2:0]             metadata2,
    output logic [2:0]             metadata3,
    output logic [2:0]             metadata4,
    output logic [5:0]             duration,
    output logic [1:0]             num_notes,
    output logic                   load_new_note,
    output logic                   song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RDATA,
        S_LOAD,
        S_GUARD,
        S_WAIT_DONE,
        S_END
    } state_t;

    state_t                 state, state_next;
    logic [1:0]             song_reg;
    logic [SONG_ADDR_W-1:0] idx;
    logic [2:0]             count;
    logic                   wrap_pending;
    logic [5:0]             slot_note [4];
    logic [2:0]             slot_md   [4];

    logic                   entry_last;
    logic [5:0]             entry_note;
    logic [5:0]             entry_dur;
    logic [2:0]             entry_md;
    logic                   sentinel;
    logic                   idx_wrap;
    logic [SONG_ADDR_W-1:0] idx_inc;
    logic [2:0]             count_add;
    logic [2:0]             count_m1;
    logic [5:0]             merged_note [4];
    logic [2:0]             merged_md   [4];

    assign entry_last = rom_data[15];
    assign entry_note = rom_data[14:9];
    assign entry_dur  = rom_data[8:3];
    assign entry_md   = rom_data[2:0];
    assign sentinel   = (rom_data == 16'h0000);
    assign idx_wrap   = &idx;
    assign idx_inc    = idx + 1'b1;
    assign count_add  = (count < 3'd4) ? count + 3'd1 : count;
    assign count_m1   = count_add - 3'd1;

    // Slot contents as they will look once the current entry is accepted; notes past the fourth are dropped.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            merged_note[i] = slot_note[i];
            merged_md[i]   = slot_md[i];
        end
        if (count < 3'd4) begin
            merged_note[count[1:0]] = entry_note;
            merged_md[count[1:0]]   = entry_md;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A paused read goes back to FETCH so the ROM word is re-read after resuming.
    always_comb begin
        state_next    = state;
        load_new_note = 1'b0;
        song_done     = 1'b0;
        if (new_song) begin
            state_next = S_FETCH;
        end else if (!play_enable) begin
            if (state == S_RDATA) begin
                state_next = S_FETCH;
            end
        end else begin
            case (state)
                S_IDLE:  state_next = S_IDLE;
                S_FETCH: state_next = S_RDATA;
                S_RDATA: begin
                    if (sentinel) begin
                        state_next = S_END;
                    end else if (entry_last) begin
                        state_next = S_LOAD;
                    end else if (idx_wrap) begin
                        state_next = S_END;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
                S_LOAD: begin
                    load_new_note = 1'b1;
                    state_next    = S_GUARD;
                end
                S_GUARD: state_next = S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (done_with_note) begin
                        state_next = wrap_pending ? S_END : S_FETCH;
                    end
                end
                S_END: begin
                    song_done  = 1'b1;
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || new_song) begin
            song_reg     <= reset ? 2'd0 : song;
            idx          <= '0;
            count        <= 3'd0;
            wrap_pending <= 1'b0;
            rom_addr     <= reset ? '0 : {song, {SONG_ADDR_W{1'b0}}};
            for (int i = 0; i < 4; i++) begin
                slot_note[i] <= 6'd0;
                slot_md[i]   <= 3'd0;
            end
            note1     <= 6'd0;
            note2     <= 6'd0;
            note3     <= 6'd0;
            note4     <= 6'd0;
            metadata1 <= 3'd0;
            metadata2 <= 3'd0;
            metadata3 <= 3'd0;
            metadata4 <= 3'd0;
            duration  <= 6'd0;
            num_notes <= 2'd0;
        end else if (play_enable) begin
            // rom_addr is updated on the way into FETCH so it is stable for the synchronous ROM.
            if (state == S_RDATA && !sentinel) begin
                for (int i = 0; i < 4; i++) begin
                    slot_note[i] <= merged_note[i];
                    slot_md[i]   <= merged_md[i];
                end
                count <= count_add;
                idx   <= idx_inc;
                if (idx_wrap) begin
                    wrap_pending <= 1'b1;
                end
                if (entry_last) begin
                    note1     <= merged_note[0];
                    note2     <= merged_note[1];
                    note3     <= merged_note[2];
                    note4     <= merged_note[3];
                    metadata1 <= merged_md[0];
                    metadata2 <= merged_md[1];
                    metadata3 <= merged_md[2];
                    metadata4 <= merged_md[3];
                    duration  <= entry_dur;
                    num_notes <= count_m1[1:0];
                end else if (!idx_wrap) begin
                    rom_addr <= {song_reg, idx_inc};
                end
            end else if (state == S_WAIT_DONE && done_with_note) begin
                count <= 3'd0;
                for (int i = 0; i < 4; i++) begin
                    slot_note[i] <= 6'd0;
                    slot_md[i]   <= 3'd0;
                end
                note1     <= 6'd0;
                note2     <= 6'd0;
                note3     <= 6'd0;
                note4     <= 6'd0;
                metadata1 <= 3'd0;
                metadata2 <= 3'd0;
                metadata3 <= 3'd0;
                metadata4 <= 3'd0;
                if (!wrap_pending) begin
                    rom_addr <= {song_reg, idx};
                end
            end
        end
    end

endmodule

// File: tb/tb_chord_sequencer.sv
// Directed bench for chord_sequencer: a synchronous song ROM model plus hand-computed
// expectations for chord grouping, timing, pausing, abort and end-of-song handling.
module tb_chord_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_enable;
    logic        new_song;
    logic [1:0]  song;
    logic        done_with_note;
    logic [6:0]  rom_addr;
    logic [15:0] rom_data;
    logic [5:0]  note1, note2, note3, note4;
    logic [2:0]  metadata1, metadata2, metadata3, metadata4;
    logic [5:0]  duration;
    logic [1:0]  num_notes;
    logic        load_new_note;
    logic        song_done;

    logic [15:0] rom [128];
    int          checks = 0;
    int          passes = 0;
    int          cnt;
    bit          sd_seen;

    chord_sequencer #(.SONG_ADDR_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .play_enable    (play_enable),
        .new_song       (new_song),
        .song           (song),
        .done_with_note (done_with_note),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .note1          (note1),
        .note2          (note2),
        .note3          (note3),
        .note4          (note4),
        .metadata1      (metadata1),
        .metadata2      (metadata2),
        .metadata3      (metadata3),
        .metadata4      (metadata4),
        .duration       (duration),
        .num_notes      (num_notes),
        .load_new_note  (load_new_note),
        .song_done      (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic logic [15:0] entry(input logic last, input logic [5:0] n,
                                          input logic [5:0] d, input logic [2:0] m);
        return {last, n, d, m};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
        end
    endtask

    // Drive inputs, then advance one clock and settle #1 past the edge.
    task automatic applyStimulus(input logic ns, input logic [1:0] sg, input logic pe, input logic dn);
        new_song       = ns;
        song           = sg;
        play_enable    = pe;
        done_with_note = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic waitLoad(output int n, output bit sd);
        n  = -1;
        sd = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
            if (song_done) sd = 1'b1;
            if (load_new_note) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic waitSongDone(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
            if (song_done) begin
                n = i;
                break;
            end
        end
    endtask

    // From LOAD: pass GUARD, reach WAIT_DONE, then hand back done_with_note for one cycle.
    task automatic finishChord();
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        done_with_note = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[7'h40] = entry(1'b1, 6'd40, 6'd12, 3'd0);
        rom[7'h20] = entry(1'b0, 6'd10, 6'd1, 3'd1);
        rom[7'h21] = entry(1'b0, 6'd14, 6'd2, 3'd2);
        rom[7'h22] = entry(1'b1, 6'd17, 6'd24, 3'd3);
        for (int i = 0; i < 5; i++) rom[7'h23 + i] = entry(i == 4, 6'(i + 1), 6'd5, 3'(i));
        rom[7'h28] = entry(1'b1, 6'd33, 6'd7, 3'd6);
        rom[7'h00] = entry(1'b0, 6'd20, 6'd3, 3'd1);
        rom[7'h01] = entry(1'b1, 6'd21, 6'd9, 3'd2);
        rom[7'h02] = entry(1'b1, 6'd22, 6'd4, 3'd0);
        for (int i = 0; i < 32; i++) rom[7'h60 + i] = entry(1'b1, 6'(i + 1), 6'd1, 3'd0);

        reset = 1'b1;
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        checkOutput("rst_rom_addr", rom_addr, 0);
        checkOutput("rst_load", load_new_note, 0);
        checkOutput("rst_song_done", song_done, 0);
        checkOutput("rst_note1", note1, 0);
        checkOutput("rst_num_notes", num_notes, 0);
        checkOutput("rst_duration", duration, 0);

        // Single-note chord on song 2.
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
        checkOutput("t1_rom_addr", rom_addr, 7'h40);
        waitLoad(cnt, sd_seen);
        checkOutput("t1_latency", cnt, 2);
        checkOutput("t1_note1", note1, 40);
        checkOutput("t1_note2", note2, 0);
        checkOutput("t1_note4", note4, 0);
        checkOutput("t1_num_notes", num_notes, 0);
        checkOutput("t1_duration", duration, 12);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("t1_load_pulse_width", load_new_note, 0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        done_with_note = 1'b0;
        checkOutput("t1_cleared_note1", note1, 0);
        checkOutput("t1_next_addr", rom_addr, 7'h41);
        waitSongDone(cnt);
        checkOutput("t1_song_done_latency", cnt, 2);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("t1_song_done_width", song_done, 0);

        // Three-entry chord on song 1.
        applyStimulus(1'b1, 2'd1, 1'b1, 1'b0);
        waitLoad(cnt, sd_seen);
        checkOutput("t2_latency", cnt, 6);
        checkOutput("t2_note1", note1, 10);
        checkOutput("t2_note2", note2, 14);
        checkOutput("t2_note3", note3, 17);
        checkOutput("t2_note4", note4, 0);
        checkOutput("t2_md1", metadata1, 1);
        checkOutput("t2_md3", metadata3, 3);
        checkOutput("t2_md4", metadata4, 0);
        checkOutput("t2_num_notes", num_notes, 2);
        checkOutput("t2_duration", duration, 24);

        // done_with_note held through LOAD and GUARD must not advance.
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("t4_hold_note1", note1, 10);
        checkOutput("t4_hold_addr", rom_addr, 7'h22);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
        done_with_note = 1'b0;
        checkOutput("t4_advance_addr", rom_addr, 7'h23);
        checkOutput("t4_advance_note1", note1, 0);

        // Five entries in one chord: the fifth note is dropped.
        waitLoad(cnt, sd_seen);
        checkOutput("t3_latency", cnt, 10);
        checkOutput("t3_note1", note1, 1);
        checkOutput("t3_note2", note2, 2);
        checkOutput("t3_note3", note3, 3);
        checkOutput("t3_note4", note4, 4);
        checkOutput("t3_md4", metadata4, 3);
        checkOutput("t3_num_notes", num_notes, 3);
        checkOutput("t3_duration", duration, 5);
        finishChord();
        checkOutput("t3_next_addr", rom_addr, 7'h28);
        waitLoad(cnt, sd_seen);
        checkOutput("t3_next_latency", cnt, 2);
        checkOutput("t3_next_note1", note1, 33);
        checkOutput("t3_next_md1", metadata1, 6);
        checkOutput("t3_next_num_notes", num_notes, 0);

        // Sentinel ends the song with one song_done pulse.
        finishChord();
        waitSongDone(cnt);
        checkOutput("t5_song_done_latency", cnt, 2);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b1, 1'b1);
            if (song_done || load_new_note) cnt++;
        end
        done_with_note = 1'b0;
        checkOutput("t5_idle_quiet", cnt, 0);
        checkOutput("t5_idle_addr", rom_addr, 7'h29);

        // Pause during RDATA, then resume on the same entry.
        applyStimulus(1'b1, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
            if (load_new_note || song_done || rom_addr != 7'h00 || note1 != 6'd0) cnt++;
        end
        checkOutput("t6_pause_frozen", cnt, 0);
        waitLoad(cnt, sd_seen);
        checkOutput("t6_resume_latency", cnt, 4);
        checkOutput("t6_note1", note1, 20);
        checkOutput("t6_note2", note2, 21);
        checkOutput("t6_md2", metadata2, 2);
        checkOutput("t6_num_notes", num_notes, 1);
        checkOutput("t6_duration", duration, 9);

        // new_song in WAIT_DONE aborts and restarts song 2 from idx 0.
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b1, 1'b0);
        checkOutput("t6_abort_addr", rom_addr, 7'h40);
        checkOutput("t6_abort_note1", note1, 0);
        checkOutput("t6_abort_note2", note2, 0);
        checkOutput("t6_abort_num_notes", num_notes, 0);
        checkOutput("t6_abort_duration", duration, 0);
        checkOutput("t6_abort_song_done", song_done, 0);
        waitLoad(cnt, sd_seen);
        checkOutput("t6_restart_latency", cnt, 2);
        checkOutput("t6_restart_no_song_done", sd_seen, 0);
        checkOutput("t6_restart_note1", note1, 40);
        finishChord();
        waitSongDone(cnt);
        checkOutput("t6_song2_done", cnt, 2);

        // Song 3 fills every index with single-note chords: idx wraps, then song ends.
        applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            waitLoad(cnt, sd_seen);
            checkOutput($sformatf("wrap_note1_%0d", i), {cnt[7:0], 2'b00, note1}, {8'd2, 2'b00, 6'(i + 1)});
            if (cnt < 0) break;
            finishChord();
        end
        checkOutput("wrap_song_done", song_done, 1);
        checkOutput("wrap_addr_hold", rom_addr, 7'h7f);
        applyStimulus(1'b0, 2'd0, 1'b1, 1'b0);
        checkOutput("wrap_song_done_width", song_done, 0);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
